input_switch_conditioner: RTL

// Front end for the CPU input port. Synchronises raw board switches and the
// "enter" push-button to clk and debounces the button. It drives the CPU's
// in_port/ready_in pair so that in_port is stable for SETUP_CYCLES before ready_in

---
 rtl/input_switch_conditioner.sv | 120 ++++++++++++
 1 files changed

// File: rtl/input_switch_conditioner.sv
// CPU input-port front end: synchronises switches and the enter button, debounces
// the button and presents in_port a fixed number of cycles before ready_in rises.
module input_switch_conditioner #(
  parameter int BUS_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETUP_CYCLES    = 2
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [BUS_WIDTH-1:0] raw_sw,
  input  logic                 raw_btn,
  output logic [BUS_WIDTH-1:0] in_port,
  output logic                 ready_in,
  output logic                 press_pulse
);

  localparam int MAX_CNT = (DEBOUNCE_CYCLES > SETUP_CYCLES) ? DEBOUNCE_CYCLES : SETUP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    SETUP,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BUS_WIDTH-1:0] sw_meta, sw_s;
  logic                 btn_meta, btn_s;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sw_meta  <= '0;
      sw_s     <= '0;
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      sw_meta  <= raw_sw;
      sw_s     <= sw_meta;
      btn_meta <= raw_btn;
      btn_s    <= btn_meta;
    end
  end

  // cnt only advances while strictly below the current state's limit, so it never wraps.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      in_port     <= '0;
      ready_in    <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        IDLE: begin
          ready_in <= 1'b0;
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            in_port <= sw_s;
            cnt     <= '0;
            state   <= SETUP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SETUP: begin
          ready_in <= 1'b0;
          if (cnt == SETUP_LAST) begin
            state       <= HELD;
            cnt         <= '0;
            ready_in    <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          ready_in <= 1'b1;
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_in <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          ready_in <= 1'b0;
        end
      endcase
    end
  end

endmodule
